// File: rtl/beat_judge.sv
// Beat circle judge: runs one approach countdown at a time, judges the lane key press,
// and keeps saturating health/score for the game state machine.
module beat_judge #(
  parameter int APPROACH_FRAMES = 60,
  parameter int PERFECT_WIN     = 4,
  parameter int GOOD_WIN        = 12,
  parameter int RESULT_FRAMES   = 20,
  parameter int HEALTH_INIT     = 6,
  parameter int HEALTH_MAX      = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        clear,
  input  logic        spawn,
  input  logic [1:0]  circletype,
  input  logic [7:0]  keycode,
  output logic        out_of_bounds,
  output logic        circle_live,
  output logic [1:0]  active_type,
  output logic [7:0]  frames_left,
  output logic [1:0]  judgement,
  output logic [3:0]  health,
  output logic [15:0] score,
  output logic [1:0]  dbg_state_o
);

  localparam logic [7:0] APPROACH_INIT = 8'(APPROACH_FRAMES);
  localparam logic [7:0] PERFECT_LIM   = 8'(PERFECT_WIN);
  localparam logic [7:0] GOOD_LIM      = 8'(GOOD_WIN);
  localparam logic [7:0] RESULT_LAST   = 8'(RESULT_FRAMES - 1);
  localparam logic [3:0] HEALTH_RST    = 4'(HEALTH_INIT);
  localparam logic [4:0] HEALTH_CEIL   = 5'(HEALTH_MAX);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_APPROACH = 2'd1,
    S_RESULT   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [7:0]  left_q, left_d;
  logic [1:0]  judge_q, judge_d;
  logic [3:0]  health_q, health_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [7:0]  prev_key_q;
  logic        oob_q, live_q;
  logic [7:0]  lane_key;
  logic        press;
  logic [4:0]  health_sum;
  logic [16:0] score_sum;

  always_comb begin
    lane_key = 8'h07;
    case (type_q)
      2'b00:   lane_key = 8'h07;
      2'b01:   lane_key = 8'h09;
      2'b10:   lane_key = 8'h0D;
      default: lane_key = 8'h0E;
    endcase
  end

  // A held key only counts on the cycle it first appears.
  assign press = (keycode == lane_key) && (keycode != prev_key_q);

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    left_d     = left_q;
    judge_d    = judge_q;
    rcnt_d     = rcnt_q;
    health_sum = {1'b0, health_q};
    score_sum  = {1'b0, score_q};
    unique case (state_q)
      S_IDLE: begin
        if (spawn) begin
          state_d = S_APPROACH;
          type_d  = circletype;
          left_d  = APPROACH_INIT;
        end
      end
      S_APPROACH: begin
        // A press inside the windows wins over a tick, even the tick that would miss.
        if (press && (left_q <= GOOD_LIM)) begin
          state_d = S_RESULT;
          rcnt_d  = 8'd0;
          if (left_q <= PERFECT_LIM) begin
            judge_d    = 2'b01;
            health_sum = {1'b0, health_q} + 5'd2;
            score_sum  = {1'b0, score_q} + 17'd300;
          end else begin
            judge_d    = 2'b10;
            health_sum = {1'b0, health_q} + 5'd1;
            score_sum  = {1'b0, score_q} + 17'd100;
          end
        end else if (frame_tick) begin
          if (left_q != 8'd0) begin
            left_d = left_q - 8'd1;
          end else begin
            state_d    = S_RESULT;
            rcnt_d     = 8'd0;
            judge_d    = 2'b11;
            health_sum = (health_q >= 4'd2) ? ({1'b0, health_q} - 5'd2) : 5'd0;
          end
        end
      end
      S_RESULT: begin
        if (frame_tick) begin
          if (rcnt_q == RESULT_LAST) begin
            state_d = S_IDLE;
            judge_d = 2'b00;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    health_d = (health_sum > HEALTH_CEIL) ? HEALTH_CEIL[3:0] : health_sum[3:0];
    score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      state_q    <= S_IDLE;
      type_q     <= 2'b00;
      left_q     <= 8'd0;
      judge_q    <= 2'b00;
      rcnt_q     <= 8'd0;
      health_q   <= HEALTH_RST;
      score_q    <= 16'd0;
      prev_key_q <= 8'd0;
      oob_q      <= 1'b1;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      left_q     <= left_d;
      judge_q    <= judge_d;
      rcnt_q     <= rcnt_d;
      health_q   <= health_d;
      score_q    <= score_d;
      prev_key_q <= keycode;
      oob_q      <= (state_d == S_IDLE);
      live_q     <= (state_d == S_APPROACH);
    end
  end

  assign out_of_bounds = oob_q;
  assign circle_live   = live_q;
  assign active_type   = type_q;
  assign frames_left   = left_q;
  assign judgement     = judge_q;
  assign health        = health_q;
  assign score         = score_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_beat_judge.sv
// Bench for beat_judge: directed vector table, corner sequences for health limits and
// score saturation, then random traffic against a rule-level reference model.
module tb_beat_judge;

  logic        Clk = 1'b0;
  logic        Reset, frame_tick, clear, spawn;
  logic [1:0]  circletype;
  logic [7:0]  keycode;
  logic        out_of_bounds, circle_live;
  logic [1:0]  active_type, judgement, dbg_state;
  logic [7:0]  frames_left;
  logic [3:0]  health;
  logic [15:0] score;

  int errors = 0;
  int checks = 0;

  beat_judge dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .clear(clear), .spawn(spawn),
    .circletype(circletype), .keycode(keycode), .out_of_bounds(out_of_bounds),
    .circle_live(circle_live), .active_type(active_type), .frames_left(frames_left),
    .judgement(judgement), .health(health), .score(score), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  bit [7:0] lane_keys[4] = '{8'h07, 8'h09, 8'h0D, 8'h0E};
  int m_phase;   // 0 no circle, 1 approaching, 2 showing result
  int m_type, m_left, m_judge, m_health, m_score, m_prev, m_shown;

  task automatic model_step(bit rst, bit clr, bit spw, bit [1:0] typ, bit [7:0] key, bit tick);
    bit pressed;
    if (rst || clr) begin
      m_phase = 0; m_type = 0; m_left = 0; m_judge = 0;
      m_health = 6; m_score = 0; m_prev = 0; m_shown = 0;
      return;
    end
    pressed = (int'(key) == int'(lane_keys[m_type])) && (int'(key) != m_prev);
    m_prev = key;
    if (m_phase == 0) begin
      if (spw) begin
        m_phase = 1; m_type = typ; m_left = 60;
      end
    end else if (m_phase == 1) begin
      if (pressed && m_left <= 12) begin
        m_phase = 2; m_shown = 0;
        m_judge  = (m_left <= 4) ? 1 : 2;
        m_health = m_health + ((m_left <= 4) ? 2 : 1);
        m_score  = m_score + ((m_left <= 4) ? 300 : 100);
        if (m_health > 15) m_health = 15;
        if (m_score > 65535) m_score = 65535;
      end else if (tick) begin
        if (m_left > 0) m_left--;
        else begin
          m_phase = 2; m_shown = 0; m_judge = 3;
          m_health = (m_health < 2) ? 0 : m_health - 2;
        end
      end
    end else begin
      if (tick) begin
        m_shown++;
        if (m_shown == 20) begin
          m_phase = 0; m_judge = 0;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("oob", out_of_bounds, (m_phase == 0) ? 1 : 0);
    chk("live", circle_live, (m_phase == 1) ? 1 : 0);
    chk("type", active_type, m_type);
    chk("left", frames_left, m_left);
    chk("judge", judgement, m_judge);
    chk("health", health, m_health);
    chk("score", score, m_score);
    chk("state_legal", (dbg_state != 2'd3) ? 1 : 0, 1);
  endtask

  // ---------------- drivers ----------------
  task automatic step(bit rst, bit clr, bit spw, bit [1:0] typ, bit [7:0] key, bit tick);
    Reset = rst; clear = clr; spawn = spw; circletype = typ; keycode = key; frame_tick = tick;
    @(posedge Clk);
    model_step(rst, clr, spw, typ, key, tick);
    #1;
    chk_model();
  endtask

  // outcome: 0 miss, 1 perfect, 2 good
  task automatic run_circle(bit [1:0] typ, int outcome, int exp_health);
    step(0, 0, 1, typ, 8'h00, 0);
    if (outcome == 0) begin
      repeat (61) step(0, 0, 0, 0, 8'h00, 1);
    end else begin
      repeat ((outcome == 1) ? 56 : 50) step(0, 0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 0, lane_keys[typ], 0);
    end
    repeat (20) step(0, 0, 0, 0, 8'h00, 1);
    chk("circle_health", health, exp_health);
    chk("circle_idle", out_of_bounds, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, clr, spw;
    bit [1:0] typ;
    bit [7:0] key;
    bit tick;
    int reps;
    int e_oob, e_judge, e_health, e_score, e_left;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit clr, bit spw, bit [1:0] typ, bit [7:0] key, bit tick,
                              int reps, int oob, int jd, int h, int s, int l);
    vec_t v;
    v.rst = rst; v.clr = clr; v.spw = spw; v.typ = typ; v.key = key; v.tick = tick; v.reps = reps;
    v.e_oob = oob; v.e_judge = jd; v.e_health = h; v.e_score = s; v.e_left = l;
    return v;
  endfunction

  bit [7:0] key_pool[7] = '{8'h00, 8'h07, 8'h09, 8'h0D, 8'h0E, 8'h14, 8'h2C};

  initial begin
    bit [7:0] rkey;
    Reset = 1'b1; clear = 1'b0; spawn = 1'b0; circletype = 2'b00; keycode = 8'h00; frame_tick = 1'b0;

    //              rst clr spw typ key   tick reps  oob jd h  s    left
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1,   1, 0, 6, 0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 5,   1, 0, 6, 0,   0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 1,   0, 0, 6, 0,   60));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 56,  0, 0, 6, 0,   4));
    vecs.push_back(mk(0, 0, 0, 0, 8'h09, 0, 1,   0, 1, 8, 300, 4));
    vecs.push_back(mk(0, 0, 1, 2, 8'h09, 1, 19,  0, 1, 8, 300, 4));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1,   1, 0, 8, 300, 4));
    vecs.push_back(mk(0, 0, 1, 3, 8'h00, 0, 1,   0, 0, 8, 300, 60));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 50,  0, 0, 8, 300, 10));
    vecs.push_back(mk(0, 0, 0, 0, 8'h0E, 0, 1,   0, 2, 9, 400, 10));
    vecs.push_back(mk(0, 0, 0, 0, 8'h0E, 0, 30,  0, 2, 9, 400, 10));
    vecs.push_back(mk(0, 0, 0, 0, 8'h0E, 1, 20,  1, 0, 9, 400, 10));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1,   1, 0, 6, 0,   0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 1,   0, 0, 6, 0,   60));
    vecs.push_back(mk(0, 0, 1, 3, 8'h00, 1, 20,  0, 0, 6, 0,   40));
    vecs.push_back(mk(0, 0, 0, 0, 8'h07, 0, 1,   0, 0, 6, 0,   40));
    vecs.push_back(mk(0, 0, 0, 0, 8'h14, 1, 40,  0, 0, 6, 0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h2C, 1, 1,   0, 3, 4, 0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 20,  1, 0, 4, 0,   0));
    vecs.push_back(mk(0, 0, 1, 2, 8'h00, 0, 1,   0, 0, 4, 0,   60));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 30,  0, 0, 4, 0,   30));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1,   1, 0, 6, 0,   0));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 0, 1,   1, 0, 6, 0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1,   1, 0, 6, 0,   0));
    vecs.push_back(mk(0, 0, 1, 2, 8'h00, 0, 1,   0, 0, 6, 0,   60));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 60,  0, 0, 6, 0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h0D, 1, 1,   0, 1, 8, 300, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 20,  1, 0, 8, 300, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 1,   0, 0, 8, 300, 60));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 47,  0, 0, 8, 300, 13));
    vecs.push_back(mk(0, 0, 0, 0, 8'h07, 0, 1,   0, 0, 8, 300, 13));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1,   0, 0, 8, 300, 12));
    vecs.push_back(mk(0, 0, 0, 0, 8'h07, 0, 1,   0, 2, 9, 400, 12));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 20,  1, 0, 9, 400, 12));

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++)
        step(vecs[i].rst, vecs[i].clr, vecs[i].spw, vecs[i].typ, vecs[i].key, vecs[i].tick);
      chk($sformatf("vec%0d_oob", i), out_of_bounds, vecs[i].e_oob);
      chk($sformatf("vec%0d_judge", i), judgement, vecs[i].e_judge);
      chk($sformatf("vec%0d_health", i), health, vecs[i].e_health);
      chk($sformatf("vec%0d_score", i), score, vecs[i].e_score);
      chk($sformatf("vec%0d_left", i), frames_left, vecs[i].e_left);
    end

    // Health floor: walk down to 1, then misses must stop at 0.
    step(1, 0, 0, 0, 8'h00, 0);
    run_circle(2'd1, 0, 4);
    run_circle(2'd2, 2, 5);
    run_circle(2'd3, 0, 3);
    run_circle(2'd0, 0, 1);
    run_circle(2'd1, 0, 0);
    run_circle(2'd2, 0, 0);
    // Health ceiling: climb to 14, then PERFECTs clamp at 15.
    for (int i = 1; i <= 7; i++) run_circle(2'(i), 1, 2 * i);
    run_circle(2'd3, 1, 15);
    run_circle(2'd0, 1, 15);
    chk("score_before_sat", score, 2800);
    // Score saturation at 0xFFFF.
    for (int i = 0; i < 215; i++) run_circle(2'(i), 1, 15);
    chk("score_saturated", score, 65535);

    // Random traffic against the model.
    step(1, 0, 0, 0, 8'h00, 0);
    rkey = 8'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) rkey = key_pool[$urandom_range(0, 6)];
      step($urandom_range(0, 799) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
           2'($urandom_range(0, 3)), rkey, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
